datapath_dupla_rampa: RTL and testbench
=======================================

# datapath_dupla_rampa

- Datapath responder for the dual-slope ADC control FSM.
- Consumes `enb_0`, `rst_s`, `ch_vm`, `ch_ref`, `ch_zr` and `ld`.
- Produces `enb_3` (full-scale count reached) and `Vint_z` (integrator at or below zero), which close the FSM loop.
- Contains a BCD counter chain, a digital integrator model and a BCD result register; it sits between the FSM and the display/output stage.

## Interface
- `DIGITS`, 3: number of BCD decades; full scale is 10^DIGITS counts.
- `VM_W`, 12: width of `vm`/`vref` magnitudes (unsigned).
- `ACC_W`, 24: signed integrator accumulator width; must hold `(2^VM_W-1)*10^DIGITS` plus sign.
- `ck` input, 1 bit: the only clock; rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `enb_0` input, 1 bit: counter enable.
- `rst_s` input, 1 bit: synchronous counter/flag clear, active-high.
- `ch_vm` input, 1 bit: integrate `vm`.
- `ch_ref` input, 1 bit: de-integrate `vref`.
- `ch_zr` input, 1 bit: zero the integrator.
- `ld` input, 1 bit: result load; capture on the 1→0 transition.
- `vm` input, `VM_W` bits: measured magnitude.
- `vref` input, `VM_W` bits: reference magnitude.
- `enb_3` output, 1 bit: one-cycle pulse on counter wrap.
- `Vint_z` output, 1 bit: accumulator ≤ 0.
- `dado` output, `4*DIGITS` bits: BCD result, digit 0 in bits [3:0].
- `ovf` output, 1 bit: sticky over-range flag.

## Operation
**Reset values (rst_n=0 at an edge):** counter=0, acc=0, `enb_3`=0, `Vint_z`=1, `dado`=0, `ovf`=0, `ld_d`=0, wrap flag=0. Reset overrides all other inputs.

**Counter:** DIGITS cascaded BCD decades, each 0–9.
- `rst_s`=1: counter=0, wrap flag=0, `ovf`=0, `enb_3`=0. `rst_s` beats `enb_0`. `dado` is untouched.
- `enb_0`=1: increment by 1 with decimal carry.
- All-9s to 0 transition: `enb_3`=1 for exactly that one cycle and the wrap flag is set.
- Any later wrap while the wrap flag is already 1 is an over-range event (see Configuration).
- `enb_0`=0: counter holds and `enb_3`=0.

**Integrator:** signed acc, one update per edge. Priority is `ch_zr` > `ch_vm` > `ch_ref`.
- `ch_zr`: acc=0.
- `ch_vm`: acc += zero-extended `vm`.
- `ch_ref`: acc −= zero-extended `vref`.
- None asserted: hold.
- No saturation; the `ACC_W` sizing rule prevents overflow.

**Zero detect:** `Vint_z` is registered as (acc_next ≤ 0) and therefore changes on the same edge as acc.

**Result load:**
- `ld_d` registers `ld` every cycle.
- When `ld_d`=1 and `ld`=0: `dado` ← current counter value, taken before any same-edge clear or increment.
- `dado` holds otherwise.
- `rst_s` and the `ld` falling edge on the same edge: `dado` gets the pre-clear count.

**Nominal conversion:**
1. Run-up lasts 10^DIGITS counts and ends with the `enb_3` pulse; the counter restarts at 0.
2. Run-down counts until `Vint_z`.
3. `dado` ≈ vm/vref·10^DIGITS, plus the fixed FSM response latency.

## Timing
- All outputs are registered; no combinational input→output paths.
- `enb_3` is high during the cycle following the edge where the count went all-9s→0. The FSM samples on `negedge ck`, so one cycle is sufficient.
- `Vint_z`: 0-cycle latency relative to acc. It asserts on the edge acc first reaches ≤0.
- `dado`: valid one edge after the `ld` falling edge is seen at an edge.
- Counter: 1 count per enabled edge. Full scale is 10^DIGITS edges from 0.

## Configuration
Macro: `CONTADOR_OVF_EN`.

**Defined:**
- A wrap while the wrap flag is set → `ovf`=1 (sticky until `rst_s`/`rst_n`).
- While `ovf`=1 the counter freezes at all-9s.
- The `ld` capture stores all-9s.
- `enb_3` still pulses on that wrap.

**Undefined:**
- `ovf` is tied to 0.
- The counter keeps wrapping and `dado` captures the wrapped value.
- The `ovf` port remains present.

## Test plan
1. Reset: `rst_n`=0 for 2 edges with random inputs → `dado`=0x000, `enb_3`=0, `Vint_z`=1, `ovf`=0.
2. Counter: `rst_s` pulse, then `enb_0`=1 for 1037 edges (DIGITS=3) → exactly one `enb_3` pulse after edge 1000; counter=0x037.
3. Integrator: `ch_zr` 1 edge; `vm`=1000, `ch_vm` 1000 edges; then `ch_ref` with `vref`=2000 → acc=1,000,000 after run-up; `Vint_z` rises on the 500th `ch_ref` edge.
4. Load: counter at 0x512, `ld` 1→0 → `dado`=0x512; counter keeps counting with `ld`=0 → `dado` stays 0x512; `rst_s` on the same edge as the `ld` fall → `dado` gets the pre-clear value.
5. Over-range: `vm`=3000, `vref`=1000, full FSM-style sequence. With `CONTADOR_OVF_EN`: `ovf`=1, `dado`=0x999. Without: `ovf`=0, `dado`=wrapped count.
6. Priority: `ch_zr`+`ch_vm` → acc=0; `ch_vm`+`ch_ref` → acc += `vm`; `rst_s`+`enb_0` → counter 0.

Source files
------------

// File: rtl/datapath_dupla_rampa.sv
// Datapath for the dual-slope ADC FSM: BCD counter chain, integrator model and BCD result register.
// Optional over-range detection and counter freeze are enabled by defining CONTADOR_OVF_EN.
module datapath_dupla_rampa #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned VM_W   = 12,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  enb_0,
  input  logic                  rst_s,
  input  logic                  ch_vm,
  input  logic                  ch_ref,
  input  logic                  ch_zr,
  input  logic                  ld,
  input  logic [VM_W-1:0]       vm,
  input  logic [VM_W-1:0]       vref,
  output logic                  enb_3,
  output logic                  Vint_z,
  output logic [4*DIGITS-1:0]   dado,
  output logic                  ovf
);

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, cnt_inc;
  logic                   wrap_q, wrap_d;
  logic                   enb_3_q, enb_3_d;
  logic                   all_nines, carry;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] vm_ext, vref_ext;
  logic                    vint_z_q, vint_z_d;

  logic                    ld_q;
  logic [4*DIGITS-1:0]     dado_q, dado_d;

`ifdef CONTADOR_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Ripple the decimal carry from digit 0 upwards.
  always_comb begin
    cnt_inc   = cnt_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_nines = all_nines & (cnt_q[i] == 4'd9);
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    enb_3_d = 1'b0;
`ifdef CONTADOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (rst_s) begin
      cnt_d   = '0;
      wrap_d  = 1'b0;
`ifdef CONTADOR_OVF_EN
      ovf_d   = 1'b0;
`endif
    end else if (enb_0) begin
`ifdef CONTADOR_OVF_EN
      if (ovf_q) begin
        cnt_d = cnt_q;
      end else if (all_nines && wrap_q) begin
        // Second wrap: flag over-range and park the count at all-9s.
        ovf_d   = 1'b1;
        enb_3_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
        if (all_nines) begin
          enb_3_d = 1'b1;
          wrap_d  = 1'b1;
        end
      end
`else
      cnt_d = cnt_inc;
      if (all_nines) begin
        enb_3_d = 1'b1;
        wrap_d  = 1'b1;
      end
`endif
    end
  end

  assign vm_ext   = {{(ACC_W-VM_W){1'b0}}, vm};
  assign vref_ext = {{(ACC_W-VM_W){1'b0}}, vref};

  always_comb begin
    acc_d = acc_q;
    if (ch_zr) begin
      acc_d = '0;
    end else if (ch_vm) begin
      acc_d = acc_q + vm_ext;
    end else if (ch_ref) begin
      acc_d = acc_q - vref_ext;
    end
    vint_z_d = acc_d[ACC_W-1] | ~(|acc_d);
  end

  // Capture uses the pre-edge count, so a same-edge clear or increment is not seen.
  always_comb begin
    dado_d = dado_q;
    if (ld_q && !ld) begin
      dado_d = cnt_q;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      enb_3_q  <= 1'b0;
      acc_q    <= '0;
      vint_z_q <= 1'b1;
      ld_q     <= 1'b0;
      dado_q   <= '0;
`ifdef CONTADOR_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      enb_3_q  <= enb_3_d;
      acc_q    <= acc_d;
      vint_z_q <= vint_z_d;
      ld_q     <= ld;
      dado_q   <= dado_d;
`ifdef CONTADOR_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign enb_3  = enb_3_q;
  assign Vint_z = vint_z_q;
  assign dado   = dado_q;
`ifdef CONTADOR_OVF_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_dupla_rampa.sv
// Directed bench for datapath_dupla_rampa: vector table plus multi-cycle conversion sequences.
module tb_datapath_dupla_rampa;

  logic        ck = 1'b0;
  logic        rst_n, enb_0, rst_s, ch_vm, ch_ref, ch_zr, ld;
  logic [11:0] vm, vref;
  logic        enb_3, Vint_z, ovf;
  logic [11:0] dado;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_dupla_rampa dut (
    .ck     (ck),
    .rst_n  (rst_n),
    .enb_0  (enb_0),
    .rst_s  (rst_s),
    .ch_vm  (ch_vm),
    .ch_ref (ch_ref),
    .ch_zr  (ch_zr),
    .ld     (ld),
    .vm     (vm),
    .vref   (vref),
    .enb_3  (enb_3),
    .Vint_z (Vint_z),
    .dado   (dado),
    .ovf    (ovf)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic        rst_s, enb_0, ch_zr, ch_vm, ch_ref, ld;
    logic [11:0] vm, vref;
    logic        e_enb_3, e_vint_z;
    logic [11:0] e_dado;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    rst_s = 0; enb_0 = 0; ch_zr = 0; ch_vm = 0; ch_ref = 0; ld = 0;
  endtask

  // Capture the held count into dado: ld high for one edge, then low.
  task automatic capture();
    enb_0 = 0; rst_s = 0; ld = 1;
    step();
    ld = 0;
    step();
  endtask

  int pulses, pulse_edge, rise_edge;
  logic [11:0] exp_dado;
  logic        exp_ovf;
  int          exp_pulses;

  initial begin
    //                rs en zr vm rf ld  vm    vref    e3 vz dado     ovf
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 12'd0, 12'd0,   0, 1, 12'h000, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 12'd5, 12'd0,   0, 0, 12'h000, 0};
    vecs[2]  = '{0, 1, 1, 1, 0, 0, 12'd7, 12'd0,   0, 1, 12'h000, 0};
    vecs[3]  = '{0, 1, 0, 1, 1, 0, 12'd3, 12'd100, 0, 0, 12'h000, 0};
    vecs[4]  = '{0, 1, 0, 0, 1, 1, 12'd0, 12'd3,   0, 1, 12'h000, 0};
    vecs[5]  = '{0, 1, 0, 0, 1, 0, 12'd0, 12'd1,   0, 1, 12'h004, 0};
    vecs[6]  = '{1, 1, 0, 1, 0, 0, 12'd2, 12'd0,   0, 0, 12'h004, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, 1, 12'd0, 12'd1,   0, 1, 12'h004, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 12'd0, 12'd0,   0, 1, 12'h000, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 1, 12'd0, 12'd0,   0, 1, 12'h000, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 12'd0, 12'd0,   0, 1, 12'h001, 0};

    // Reset with random inputs
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      {rst_s, enb_0, ch_zr, ch_vm, ch_ref, ld} = 6'($urandom);
      vm = 12'($urandom); vref = 12'($urandom);
      step();
    end
    check("reset_dado", dado, 12'h000);
    check("reset_enb_3", enb_3, 1'b0);
    check("reset_vint_z", Vint_z, 1'b1);
    check("reset_ovf", ovf, 1'b0);
    idle(); vm = 0; vref = 0;
    rst_n = 1;

    // Vector table: counter, integrator priority, load edge
    for (int i = 0; i < 11; i++) begin
      rst_s = vecs[i].rst_s; enb_0 = vecs[i].enb_0; ch_zr = vecs[i].ch_zr;
      ch_vm = vecs[i].ch_vm; ch_ref = vecs[i].ch_ref; ld = vecs[i].ld;
      vm = vecs[i].vm; vref = vecs[i].vref;
      step();
      check($sformatf("vec%0d_enb_3", i), enb_3, vecs[i].e_enb_3);
      check($sformatf("vec%0d_vint_z", i), Vint_z, vecs[i].e_vint_z);
      check($sformatf("vec%0d_dado", i), dado, vecs[i].e_dado);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].e_ovf);
    end
    idle();

    // Counter: 1037 enabled edges, one wrap pulse after edge 1000
    rst_s = 1; step(); rst_s = 0;
    pulses = 0; pulse_edge = -1;
    enb_0 = 1;
    for (int i = 1; i <= 1037; i++) begin
      step();
      if (enb_3) begin
        pulses++;
        pulse_edge = i;
      end
    end
    check("cnt_pulses", pulses, 1);
    check("cnt_pulse_edge", pulse_edge, 1000);
    capture();
    check("cnt_1037", dado, 12'h037);

    // Integrator: run-up 1000 x 1000, run-down by 2000
    idle();
    ch_zr = 1; step(); ch_zr = 0;
    vm = 12'd1000; ch_vm = 1;
    for (int i = 0; i < 1000; i++) step();
    ch_vm = 0;
    check("int_runup_vint_z", Vint_z, 1'b0);
    vref = 12'd2000; ch_ref = 1; rise_edge = -1;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (Vint_z) begin
        rise_edge = i;
        break;
      end
    end
    ch_ref = 0;
    check("int_rise_edge", rise_edge, 500);

    // Load: capture 512, hold while counting, capture pre-clear value under rst_s
    idle();
    rst_s = 1; step(); rst_s = 0;
    enb_0 = 1;
    for (int i = 0; i < 512; i++) step();
    capture();
    check("ld_512", dado, 12'h512);
    enb_0 = 1;
    for (int i = 0; i < 10; i++) step();
    check("ld_hold", dado, 12'h512);
    enb_0 = 0; ld = 1; step();
    ld = 0; rst_s = 1; step(); rst_s = 0;
    check("ld_preclear", dado, 12'h522);
    capture();
    check("ld_after_clear", dado, 12'h000);

    // Over-range conversion: vm = 3000, vref = 1000
    idle();
    rst_s = 1; ch_zr = 1; step(); rst_s = 0; ch_zr = 0;
    vm = 12'd3000; vref = 12'd1000;
    ch_vm = 1; enb_0 = 1; pulses = 0; pulse_edge = -1;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (enb_3) begin
        pulses++;
        pulse_edge = i;
      end
    end
    check("ovr_runup_pulses", pulses, 1);
    check("ovr_runup_edge", pulse_edge, 1000);
    ch_vm = 0; ch_ref = 1; pulses = 0; rise_edge = -1;
    for (int i = 1; i <= 4000; i++) begin
      step();
      if (enb_3) pulses++;
      if (Vint_z) begin
        rise_edge = i;
        break;
      end
    end
    ch_ref = 0; enb_0 = 0;
    check("ovr_rise_edge", rise_edge, 3000);
    capture();
`ifdef CONTADOR_OVF_EN
    exp_dado = 12'h999; exp_ovf = 1'b1; exp_pulses = 1;
`else
    exp_dado = 12'h000; exp_ovf = 1'b0; exp_pulses = 3;
`endif
    check("ovr_dado", dado, exp_dado);
    check("ovr_ovf", ovf, exp_ovf);
    check("ovr_pulses", pulses, exp_pulses);
    rst_s = 1; step(); rst_s = 0;
    check("ovr_cleared", ovf, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
